// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch front end of the 5-stage RISC-V pipeline. Owns the fetch
// PC, presents it to the BTB and instruction memory, and picks the next PC
// (redirect > hold > BTB target > PC+4). Accepted fetches are registered into
// the IF/ID pipeline register together with their prediction metadata, so
// execute can later detect mispredictions and update the BTB.
//
// Optional feature: define BRANCH_PERF_EN to build saturating counters of
// taken predictions issued and redirects received. Without it the counter
// ports are tied to zero and no counter flops exist.
//
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//   CNT_W     width of the performance counters
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_stall             hazard stall: hold PC and IF/ID
//   i_imem_ready        instruction memory accepts the request at o_pc
//   i_btb_hit/_target   same-cycle BTB lookup result for o_pc
//   i_redirect/_pc      execute-stage correction and the correct PC
//   o_pc                fetch PC (BTB index/tag, imem address)
//   o_if_valid          fetch request at o_pc is valid this cycle
//   o_id_*              IF/ID register: valid, PC, predicted taken, predicted next PC
//   o_flush             high the cycle after a redirect, kills decode
//   o_pred_cnt          taken predictions issued   (BRANCH_PERF_EN)
//   o_redir_cnt         redirects received         (BRANCH_PERF_EN)
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_imem_ready,
  input  logic             i_btb_hit,
  input  logic [31:0]      i_btb_target,
  input  logic             i_redirect,
  input  logic [31:0]      i_redirect_pc,
  output logic [31:0]      o_pc,
  output logic             o_if_valid,
  output logic             o_id_valid,
  output logic [31:0]      o_id_pc,
  output logic             o_id_pred_taken,
  output logic [31:0]      o_id_pred_target,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_pred_cnt,
  output logic [CNT_W-1:0] o_redir_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_WAIT_MEM
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_taken_q, id_taken_d;
  logic [31:0] id_target_q, id_target_d;
  logic        flush_q;

  logic [31:0] redirect_tgt;
  logic [31:0] pred_next;
  logic        id_load;

  // Targets are forced to word alignment; low bits from the sources are ignored.
  assign redirect_tgt = i_redirect_pc & ~32'h3;
  assign pred_next    = i_btb_hit ? (i_btb_target & ~32'h3) : (pc_q + 32'd4);

  // A fetch is accepted only in RUN; WAIT_MEM re-issues the held PC first.
  assign id_load = (state_q == S_RUN) && i_imem_ready && !i_stall && !i_redirect;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    o_if_valid  = (state_q != S_BOOT);
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_taken_d  = id_taken_q;
    id_target_d = id_target_q;

    unique case (state_q)
      S_BOOT:     state_d = S_RUN;
      S_RUN:      if (!i_redirect && !i_imem_ready) state_d = S_WAIT_MEM;
      S_WAIT_MEM: if (i_redirect || i_imem_ready) state_d = S_RUN;
      default:    state_d = S_BOOT;
    endcase

    // PC advances exactly when a fetch is accepted; a redirect always wins.
    if (i_redirect) begin
      pc_d = redirect_tgt;
    end else if (id_load) begin
      pc_d = pred_next;
    end

    if (i_redirect) begin
      id_valid_d = 1'b0;
    end else if (id_load) begin
      id_valid_d  = 1'b1;
      id_pc_d     = pc_q;
      id_taken_d  = i_btb_hit;
      id_target_d = pred_next;
    end else if (!i_stall) begin
      id_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      id_taken_q  <= 1'b0;
      id_target_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_taken_q  <= id_taken_d;
      id_target_q <= id_target_d;
      flush_q     <= i_redirect;
    end
  end

  assign o_pc             = pc_q;
  assign o_id_valid       = id_valid_q;
  assign o_id_pc          = id_pc_q;
  assign o_id_pred_taken  = id_taken_q;
  assign o_id_pred_target = id_target_q;
  assign o_flush          = flush_q;

`ifdef BRANCH_PERF_EN
  logic [CNT_W-1:0] pred_cnt_q, redir_cnt_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pred_cnt_q  <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (id_load && i_btb_hit && !(&pred_cnt_q)) pred_cnt_q <= pred_cnt_q + CNT_W'(1);
      if (i_redirect && !(&redir_cnt_q)) redir_cnt_q <= redir_cnt_q + CNT_W'(1);
    end
  end

  assign o_pred_cnt  = pred_cnt_q;
  assign o_redir_cnt = redir_cnt_q;
`else
  assign o_pred_cnt  = '0;
  assign o_redir_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Self-checking bench for fetch_pc_unit: directed scenarios followed by
// randomized traffic, every output compared each cycle against a
// transaction-level model of the fetch stage. Honours BRANCH_PERF_EN.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  localparam int unsigned   CNT_W    = 32;
  localparam logic [31:0]   RESET_PC = 32'h0000_0000;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_stall;
  logic             i_imem_ready;
  logic             i_btb_hit;
  logic [31:0]      i_btb_target;
  logic             i_redirect;
  logic [31:0]      i_redirect_pc;
  logic [31:0]      o_pc;
  logic             o_if_valid;
  logic             o_id_valid;
  logic [31:0]      o_id_pc;
  logic             o_id_pred_taken;
  logic [31:0]      o_id_pred_target;
  logic             o_flush;
  logic [CNT_W-1:0] o_pred_cnt;
  logic [CNT_W-1:0] o_redir_cnt;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_stall          (i_stall),
    .i_imem_ready     (i_imem_ready),
    .i_btb_hit        (i_btb_hit),
    .i_btb_target     (i_btb_target),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_pc             (o_pc),
    .o_if_valid       (o_if_valid),
    .o_id_valid       (o_id_valid),
    .o_id_pc          (o_id_pc),
    .o_id_pred_taken  (o_id_pred_taken),
    .o_id_pred_target (o_id_pred_target),
    .o_flush          (o_flush),
    .o_pred_cnt       (o_pred_cnt),
    .o_redir_cnt      (o_redir_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the fetch stage seen as "a fetch is accepted or not".
  logic [31:0] m_pc, m_id_pc, m_id_tgt;
  bit          m_booting, m_waiting, m_id_valid, m_id_taken, m_flush;
  int unsigned m_pred, m_redir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = RESET_PC;
    m_booting  = 1'b1;
    m_waiting  = 1'b0;
    m_id_valid = 1'b0;
    m_id_pc    = '0;
    m_id_taken = 1'b0;
    m_id_tgt   = '0;
    m_flush    = 1'b0;
    m_pred     = 0;
    m_redir    = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit          issuing = !m_booting && !m_waiting;
    bit          accept  = issuing && i_imem_ready && !i_stall && !i_redirect;
    logic [31:0] guess;
    guess = i_btb_hit ? {i_btb_target[31:2], 2'b00} : m_pc + 32'd4;

    m_flush = i_redirect;
    if (i_redirect) begin
      m_id_valid = 1'b0;
      if (m_redir != 32'hFFFF_FFFF) m_redir++;
    end else if (accept) begin
      m_id_valid = 1'b1;
      m_id_pc    = m_pc;
      m_id_taken = i_btb_hit;
      m_id_tgt   = guess;
      if (i_btb_hit && m_pred != 32'hFFFF_FFFF) m_pred++;
    end else if (!i_stall) begin
      m_id_valid = 1'b0;
    end

    m_waiting = !i_redirect && !m_booting && !i_imem_ready;
    if (i_redirect) m_pc = {i_redirect_pc[31:2], 2'b00};
    else if (accept) m_pc = guess;
    m_booting = 1'b0;
  endtask

  task automatic compare_all(input string where);
    logic [31:0] exp_pred, exp_redir;
`ifdef BRANCH_PERF_EN
    exp_pred  = m_pred;
    exp_redir = m_redir;
`else
    exp_pred  = '0;
    exp_redir = '0;
`endif
    check({where, " pc"},          o_pc,             m_pc);
    check({where, " if_valid"},    o_if_valid,       !m_booting);
    check({where, " id_valid"},    o_id_valid,       m_id_valid);
    check({where, " id_pc"},       o_id_pc,          m_id_pc);
    check({where, " id_taken"},    o_id_pred_taken,  m_id_taken);
    check({where, " id_target"},   o_id_pred_target, m_id_tgt);
    check({where, " flush"},       o_flush,          m_flush);
    check({where, " pred_cnt"},    o_pred_cnt,       exp_pred);
    check({where, " redir_cnt"},   o_redir_cnt,      exp_redir);
  endtask

  task automatic drive(input bit stall, input bit ready, input bit hit,
                       input logic [31:0] tgt, input bit redir, input logic [31:0] rpc);
    i_stall       = stall;
    i_imem_ready  = ready;
    i_btb_hit     = hit;
    i_btb_target  = tgt;
    i_redirect    = redir;
    i_redirect_pc = rpc;
  endtask

  task automatic cycle(input string where);
    model_step();
    @(posedge i_clk);
    #1;
    compare_all(where);
  endtask

  initial begin
    logic [31:0] exp_pred, exp_redir;

    // Reset state
    i_rst_n = 1'b0;
    drive(0, 1, 0, '0, 0, '0);
    model_reset();
    #12;
    compare_all("reset");
    i_rst_n = 1'b1;
    check("boot if_valid", o_if_valid, 32'd0);

    // Sequential fetch from reset
    cycle("boot");
    check("seq pc0", o_pc, 32'h0);
    cycle("seq");
    check("seq pc4", o_pc, 32'h4);
    check("seq id0", o_id_pc, 32'h0);
    cycle("seq");
    check("seq pc8", o_pc, 32'h8);
    check("seq id4", o_id_pc, 32'h4);
    cycle("seq");
    cycle("seq");
    check("seq pc10", o_pc, 32'h10);

    // BTB hit at 0x10
    drive(0, 1, 1, 32'h80, 0, '0);
    cycle("hit");
    check("hit pc", o_pc, 32'h80);
    check("hit id_pc", o_id_pc, 32'h10);
    check("hit id_taken", o_id_pred_taken, 32'd1);
    check("hit id_target", o_id_pred_target, 32'h80);

    // Redirect wins over stall
    drive(1, 1, 0, '0, 1, 32'h200);
    cycle("redir+stall");
    check("redir pc", o_pc, 32'h200);
    check("redir flush", o_flush, 32'd1);
    check("redir id_valid", o_id_valid, 32'd0);
    drive(0, 1, 0, '0, 0, '0);
    cycle("after redir");
    check("flush one cycle", o_flush, 32'd0);
    check("redir first id", o_id_pc, 32'h200);

    // Memory not ready for 3 cycles at 0x24
    drive(0, 1, 0, '0, 1, 32'h24);
    cycle("to 0x24");
    drive(0, 0, 0, '0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle("wait_mem");
      check("wait pc hold", o_pc, 32'h24);
      check("wait id bubble", o_id_valid, 32'd0);
    end
    drive(0, 1, 0, '0, 0, '0);
    cycle("mem back");
    cycle("resume");
    check("resume pc", o_pc, 32'h28);
    check("resume id_pc", o_id_pc, 32'h24);

    // Wrap-around and redirect alignment
    drive(0, 1, 0, '0, 1, 32'hFFFF_FFFC);
    cycle("to top");
    drive(0, 1, 0, '0, 0, '0);
    cycle("wrap");
    check("wrap pc", o_pc, 32'h0);
    check("wrap id_pc", o_id_pc, 32'hFFFF_FFFC);
    drive(0, 1, 0, '0, 1, 32'h203);
    cycle("align");
    check("align pc", o_pc, 32'h200);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom, $urandom_range(0, 9) == 0, $urandom);
      cycle("rand");
    end

    // Asynchronous reset mid-run, away from the clock edge
    drive(0, 1, 0, '0, 0, '0);
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async reset");
    #1 i_rst_n = 1'b1;

    // Counters: 5 taken predictions, 2 redirects
    cycle("boot2");
    drive(0, 1, 1, $urandom & ~32'h3, 0, '0);
    for (int i = 0; i < 5; i++) begin
      i_btb_target = $urandom;
      cycle("taken");
    end
    drive(0, 1, 0, '0, 1, 32'h400);
    cycle("redirect a");
    cycle("redirect b");
`ifdef BRANCH_PERF_EN
    exp_pred  = 32'd5;
    exp_redir = 32'd2;
`else
    exp_pred  = 32'd0;
    exp_redir = 32'd0;
`endif
    check("pred_cnt total", o_pred_cnt, exp_pred);
    check("redir_cnt total", o_redir_cnt, exp_redir);

    drive(0, 1, 0, '0, 0, '0);
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    check("pred_cnt cleared", o_pred_cnt, 32'd0);
    check("redir_cnt cleared", o_redir_cnt, 32'd0);
    compare_all("reset2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
